// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port MIPS register file.
package regfile_pkg;

    localparam int RF_DWIDTH    = 32;
    localparam int RF_DEPTH     = 32;
    localparam int RF_NRD       = 2;
    localparam int RF_ZERO_ADDR = 0;

    // Address width for a given register count; never narrower than one bit.
    function automatic int rf_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write bitmap: decode reserves a register, either writeback port releases it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int NRD   = RF_NRD,
    localparam int AW   = rf_addr_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            clr0_en,
    input  logic [AW-1:0]   clr0_addr,
    input  logic            clr1_en,
    input  logic [AW-1:0]   clr1_addr,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]  busy
);

    logic [DEPTH-1:0] pending_r;
    logic [DEPTH-1:0] pending_nxt_s;

    // Next pending state: a reservation beats a release on the same register.
    always_comb begin
        pending_nxt_s = pending_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == RF_ZERO_ADDR) begin
                pending_nxt_s[i] = 1'b0;
            end else begin
                pending_nxt_s[i] = (rsv_en && (rsv_addr == AW'(i))) ||
                                   (pending_r[i] &&
                                    !(clr0_en && (clr0_addr == AW'(i))) &&
                                    !(clr1_en && (clr1_addr == AW'(i))));
            end
        end
    end

    // Pending bitmap register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= {DEPTH{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Busy lookup per read port; depends on registered state only.
    always_comb begin
        busy = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            busy[i] = pending_r[ra[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// N-read / 2-write register file with r0 hard-wired to zero and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DWIDTH = RF_DWIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NRD    = RF_NRD,
    localparam int AW    = rf_addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*DWIDTH-1:0] rd,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [DWIDTH-1:0]     wd0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [DWIDTH-1:0]     wd1,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr
);

    localparam logic [AW-1:0] ZERO_A = AW'(RF_ZERO_ADDR);

    (* ram_style = "distributed" *) logic [DWIDTH-1:0] regs_r [DEPTH];

    logic           wr0_s;
    logic           wr1_s;
    logic           rsv_s;
    logic [NRD-1:0] sb_busy_s;

    assign wr0_s = we0 && (wa0 != ZERO_A);
    assign wr1_s = we1 && (wa1 != ZERO_A);
    assign rsv_s = rsv_en && (rsv_addr != ZERO_A);

    // Storage update; port 1 is written last so it wins an address conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DWIDTH{1'b0}};
            end
        end else begin
            if (wr0_s) begin
                regs_r[wa0] <= wd0;
            end
            if (wr1_s) begin
                regs_r[wa1] <= wd1;
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rsv_en    (rsv_s),
        .rsv_addr  (rsv_addr),
        .clr0_en   (wr0_s),
        .clr0_addr (wa0),
        .clr1_en   (wr1_s),
        .clr1_addr (wa1),
        .ra        (ra),
        .busy      (sb_busy_s)
    );

    // Asynchronous read ports with optional write-through forwarding.
    always_comb begin
        rd      = {(NRD*DWIDTH){1'b0}};
        rd_busy = sb_busy_s;
        for (int i = 0; i < NRD; i++) begin
            if (ra[i*AW +: AW] == ZERO_A) begin
                rd[i*DWIDTH +: DWIDTH] = {DWIDTH{1'b0}};
            end
`ifdef REGFILE_BYPASS_EN
            else if (wr1_s && (wa1 == ra[i*AW +: AW])) begin
                rd[i*DWIDTH +: DWIDTH] = wd1;
                rd_busy[i]             = 1'b0;
            end else if (wr0_s && (wa0 == ra[i*AW +: AW])) begin
                rd[i*DWIDTH +: DWIDTH] = wd0;
                rd_busy[i]             = 1'b0;
            end
`endif
            else begin
                rd[i*DWIDTH +: DWIDTH] = regs_r[ra[i*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (defaults: 32x32, two read ports).
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0]    rd_busy;
    logic              we0, we1, rsv_en;
    logic [AW-1:0]     wa0, wa1, rsv_addr;
    logic [DW-1:0]     wd0, wd1;

    int n_assert = 0;
    int n_fail   = 0;

    string       tag_q[$];
    logic [31:0] val_q[$];

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr)
    );

    task automatic push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_assert++;
        if (val_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    function automatic logic [31:0] rdp(input int p);
        return rd[p*DW +: DW];
    endfunction

    task automatic set_ra(input int p, input logic [AW-1:0] a);
        ra[p*AW +: AW] = a;
    endtask

    task automatic idle();
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
    endtask

    // Advance past the next rising edge; registered effects are then visible.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
        wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'h0; wd1 = 32'h0; rsv_addr = 5'd0;
        ra  = {(NRD*AW){1'b0}};

        // Reset state
        tick();
        idle();
        set_ra(0, 5'd1); set_ra(1, 5'd31);
        push("reset_rd0", 32'h0); push("reset_rd1", 32'h0);
        push("reset_busy0", 32'h0); push("reset_busy1", 32'h0);
        settle();
        chk(rdp(0)); chk(rdp(1)); chk({31'b0, rd_busy[0]}); chk({31'b0, rd_busy[1]});

        // Zero register: write and reservation to r0 are dropped
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1;
        tick();
        idle();
        set_ra(0, 5'd0);
        push("zero_rd0", 32'h0);
        settle(); chk(rdp(0));
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        idle();
        push("zero_busy0", 32'h0);
        settle(); chk({31'b0, rd_busy[0]});

        // Basic write then read on every port
        we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h1111_1111;
        tick();
        idle(); wd0 = 32'h1010_1010;
        set_ra(0, 5'd1); set_ra(1, 5'd1);
        push("basic_rd0", 32'h1111_1111); push("basic_rd1", 32'h1111_1111);
        settle(); chk(rdp(0)); chk(rdp(1));
        tick();
        push("basic_hold_rd0", 32'h1111_1111);
        settle(); chk(rdp(0));

        // Dual-write conflict: port 1 wins
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hAAAA_AAAA;
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h5555_5555;
        tick();
        idle();
        set_ra(0, 5'd5);
        push("conflict_r5", 32'h5555_5555);
        settle(); chk(rdp(0));

        // Scoreboard: reserve r7 at t, release via port 1 at t+3
        set_ra(0, 5'd7);
        rsv_en = 1'b1; rsv_addr = 5'd7;
        push("sb_busy_t0", 32'h0);
        settle(); chk({31'b0, rd_busy[0]});
        tick();
        idle();
        push("sb_busy_t1", 32'h1);
        settle(); chk({31'b0, rd_busy[0]});
        tick();
        push("sb_busy_t2", 32'h1);
        settle(); chk({31'b0, rd_busy[0]});
        tick();
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0000_0077;
`ifdef REGFILE_BYPASS_EN
        push("sb_busy_t3", 32'h0); push("sb_rd_t3", 32'h0000_0077);
`else
        push("sb_busy_t3", 32'h1); push("sb_rd_t3", 32'h0);
`endif
        settle(); chk({31'b0, rd_busy[0]}); chk(rdp(0));
        tick();
        idle();
        push("sb_busy_t4", 32'h0); push("sb_rd_t4", 32'h0000_0077);
        settle(); chk({31'b0, rd_busy[0]}); chk(rdp(0));

        // Reserve and write the same register in one cycle: set wins
        rsv_en = 1'b1; rsv_addr = 5'd7;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0000_7777;
        tick();
        idle();
        push("setwin_busy", 32'h1); push("setwin_rd", 32'h0000_7777);
        settle(); chk({31'b0, rd_busy[0]}); chk(rdp(0));
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h0000_0007;
        tick();
        idle();
        push("clr_port0_busy", 32'h0);
        settle(); chk({31'b0, rd_busy[0]});

        // Reset mid-operation
        for (int i = 1; i < 32; i++) begin
            we0 = 1'b1; wa0 = AW'(i); wd0 = 32'(i);
            tick();
        end
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        set_ra(0, 5'd9); set_ra(1, 5'd30);
        push("pre_rst_busy9", 32'h1); push("pre_rst_r30", 32'd30);
        settle(); chk({31'b0, rd_busy[0]}); chk(rdp(1));
        rst = 1'b1; we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_0033;
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            set_ra(0, AW'(i)); set_ra(1, AW'(31 - i));
            push("post_rst_rd0", 32'h0); push("post_rst_busy0", 32'h0);
            push("post_rst_busy1", 32'h0);
            #1;
            chk(rdp(0)); chk({31'b0, rd_busy[0]}); chk({31'b0, rd_busy[1]});
        end

        // Bypass behaviour, r4 and r6 are zero after reset
        set_ra(0, 5'd4);
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hDEAD_BEEF;
`ifdef REGFILE_BYPASS_EN
        push("bypass_rd0", 32'hDEAD_BEEF);
`else
        push("bypass_rd0", 32'h0);
`endif
        settle(); chk(rdp(0));
        tick();
        idle();
        push("bypass_commit", 32'hDEAD_BEEF);
        settle(); chk(rdp(0));
        set_ra(1, 5'd6);
        we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h0000_AAAA;
        we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h0000_BBBB;
`ifdef REGFILE_BYPASS_EN
        push("bypass_prio_rd1", 32'h0000_BBBB);
`else
        push("bypass_prio_rd1", 32'h0);
`endif
        settle(); chk(rdp(1));
        tick();
        idle();
        push("prio_commit_rd1", 32'h0000_BBBB);
        settle(); chk(rdp(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
